pdm_multichannel: RTL and testbench

- Multi-channel first-order PDM (pulse-density) modulator, WIDTH-bit resolution per channel; successor to the single-channel 5-bit modulator in the same user-module slot.
- Setpoints are loaded over a narrow nibble-serial bus, because the 8-bit scan-wrapper IO cannot carry a full word per channel.
- Each channel is double-buffered: shadow register plus active register.
- Commit is either immediate, or synchronised across all channels at a frame boundary, so multi-channel updates are glitch-coherent.

---
 rtl/pdm_pkg.sv | 19 +
 rtl/pdm_channel.sv | 42 ++++
 rtl/pdm_multichannel.sv | 123 ++++++++++++
 tb/tb_pdm_multichannel.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pdm_pkg.sv
// pdm_pkg: shared definitions for the multi-channel PDM modulator.
//   beats_per_word : number of load-bus beats that make up one setpoint word
//   ch_width       : channel-select width, never narrower than one bit
//   COMMIT_IMM / COMMIT_FRAME : commit_mode encodings
package pdm_pkg;

    localparam logic COMMIT_IMM   = 1'b0;
    localparam logic COMMIT_FRAME = 1'b1;

    function automatic int unsigned beats_per_word(input int unsigned width,
                                                   input int unsigned din_w);
        return width / din_w;
    endfunction

    function automatic int unsigned ch_width(input int unsigned channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/pdm_channel.sv
// pdm_channel: one first-order PDM modulator with its active setpoint register.
//   clk, reset : posedge clock, synchronous active-high reset
//   enable     : 1 = accumulator and output advance, 0 = hold
//   commit     : copy shadow into the active register this cycle
//   shadow     : WIDTH-bit setpoint waiting in the shadow register
//   pdm_out    : registered bitstream (carry out of the accumulator)
module pdm_channel #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             commit,
    input  logic [WIDTH-1:0] shadow,
    output logic             pdm_out
);

    logic [WIDTH-1:0] active;
    logic [WIDTH-1:0] acc;
    logic [WIDTH:0]   sum;

    assign sum = {1'b0, active} + {1'b0, acc};

    // The accumulator is deliberately left untouched on commit so the
    // bitstream stays continuous across setpoint changes.
    always_ff @(posedge clk) begin
        if (reset) begin
            active  <= '0;
            acc     <= '0;
            pdm_out <= 1'b0;
        end else begin
            if (commit) begin
                active <= shadow;
            end
            if (enable) begin
                acc     <= sum[WIDTH-1:0];
                pdm_out <= sum[WIDTH];
            end
        end
    end

endmodule

// File: rtl/pdm_multichannel.sv
// pdm_multichannel: CHANNELS double-buffered PDM modulators loaded over a
// nibble-serial bus, with immediate or frame-synchronised commit.
//   clk, reset   : posedge clock, synchronous active-high reset
//   enable       : runs modulators and frame counter
//   din          : load beat, most significant beat first
//   din_valid    : beat qualifier
//   din_first    : first beat of a word, restarts assembly
//   din_ch       : target channel, sampled on the first beat
//   commit_mode  : COMMIT_IMM or COMMIT_FRAME
//   pdm_out      : per-channel bitstreams
//   frame_tick   : one-cycle pulse when the frame counter wraps
//   pending      : shadow holds an uncommitted word
//   load_overrun : sticky, a pending shadow was overwritten
module pdm_multichannel
    import pdm_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned DIN_W    = 4,
    parameter int unsigned CH_W     = ch_width(CHANNELS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [DIN_W-1:0]    din,
    input  logic                din_valid,
    input  logic                din_first,
    input  logic [CH_W-1:0]     din_ch,
    input  logic                commit_mode,
    output logic [CHANNELS-1:0] pdm_out,
    output logic                frame_tick,
    output logic [CHANNELS-1:0] pending,
    output logic                load_overrun
);

    localparam int unsigned BEATS = beats_per_word(WIDTH, DIN_W);
    localparam int unsigned CNT_W = $clog2(BEATS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BEATS);

    logic [WIDTH-1:0]    asm_word;
    logic [CNT_W-1:0]    beat_cnt;
    logic [CH_W-1:0]     word_ch;
    logic [WIDTH-1:0]    frame_cnt;
    logic [WIDTH-1:0]    shadow [CHANNELS];
    logic                word_done;
    logic [CHANNELS-1:0] shadow_wr;
    logic [CHANNELS-1:0] commit;
    logic [CHANNELS-1:0] overwrite;

    assign word_done  = (beat_cnt == CNT_FULL);
    assign frame_tick = enable && (frame_cnt == '1);

    // A channel select outside 0..CHANNELS-1 matches no lane, so the word
    // is dropped. A shadow write that coincides with a commit does not
    // count as an overrun: the older word reaches the active register.
    always_comb begin
        shadow_wr = '0;
        commit    = '0;
        overwrite = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            shadow_wr[c] = word_done && (word_ch == CH_W'(c));
            commit[c]    = pending[c] && ((commit_mode == COMMIT_IMM) || frame_tick);
            overwrite[c] = shadow_wr[c] && pending[c] && !commit[c];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            asm_word <= '0;
            beat_cnt <= '0;
            word_ch  <= '0;
        end else if (din_valid && din_first) begin
            asm_word <= WIDTH'(din);
            beat_cnt <= CNT_W'(1);
            word_ch  <= din_ch;
        end else if (din_valid && (beat_cnt != '0) && (beat_cnt < CNT_FULL)) begin
            asm_word <= (asm_word << DIN_W) | WIDTH'(din);
            beat_cnt <= beat_cnt + CNT_W'(1);
        end else if (word_done) begin
            beat_cnt <= '0;
        end
    end

    // Setting pending wins over clearing it, so a word landing on a
    // frame-tick cycle waits for the following frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                shadow[c] <= '0;
            end
            pending      <= '0;
            load_overrun <= 1'b0;
            frame_cnt    <= '0;
        end else begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                if (shadow_wr[c]) begin
                    shadow[c] <= asm_word;
                end
            end
            pending <= shadow_wr | (pending & ~commit);
            if (|overwrite) begin
                load_overrun <= 1'b1;
            end
            if (enable) begin
                frame_cnt <= frame_cnt + WIDTH'(1);
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        pdm_channel #(
            .WIDTH(WIDTH)
        ) u_channel (
            .clk     (clk),
            .reset   (reset),
            .enable  (enable),
            .commit  (commit[g]),
            .shadow  (shadow[g]),
            .pdm_out (pdm_out[g])
        );
    end

endmodule

// File: tb/tb_pdm_multichannel.sv
// tb_pdm_multichannel: directed plus randomized bench for pdm_multichannel
// (WIDTH=8, CHANNELS=2, DIN_W=4) against a cycle-level arithmetic model.
module tb_pdm_multichannel;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] din;
    logic       din_valid;
    logic       din_first;
    logic       din_ch;
    logic       commit_mode;
    logic [1:0] pdm_out;
    logic       frame_tick;
    logic [1:0] pending;
    logic       load_overrun;

    pdm_multichannel #(
        .WIDTH    (8),
        .CHANNELS (2),
        .DIN_W    (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .din          (din),
        .din_valid    (din_valid),
        .din_first    (din_first),
        .din_ch       (din_ch),
        .commit_mode  (commit_mode),
        .pdm_out      (pdm_out),
        .frame_tick   (frame_tick),
        .pending      (pending),
        .load_overrun (load_overrun)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: integer setpoints, modular accumulation, word
    // assembled as word*16+nibble.
    int m_acc [2];
    int m_act [2];
    int m_sh  [2];
    bit m_pend[2];
    bit m_out [2];
    int m_fc;
    bit m_ovr;
    int m_cnt;
    int m_word;
    int m_ch;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < 2; c++) begin
            m_acc[c] = 0; m_act[c] = 0; m_sh[c] = 0; m_pend[c] = 0; m_out[c] = 0;
        end
        m_fc = 0; m_ovr = 0; m_cnt = 0; m_word = 0; m_ch = 0;
    endfunction

    // Applied once per rising edge, using the inputs seen at that edge.
    function automatic void model_step();
        bit tick, done, cm, wr;
        int s;
        if (reset) begin
            model_reset();
            return;
        end
        tick = enable && (m_fc == 255);
        done = (m_cnt == 2);
        for (int c = 0; c < 2; c++) begin
            cm = m_pend[c] && (commit_mode == 1'b0 || tick);
            wr = done && (m_ch == c);
            if (enable) begin
                s = m_acc[c] + m_act[c];
                m_out[c] = (s >= 256);
                m_acc[c] = s % 256;
            end
            if (wr && m_pend[c] && !cm) m_ovr = 1;
            if (cm) m_act[c] = m_sh[c];
            if (wr) m_sh[c] = m_word;
            m_pend[c] = wr ? 1'b1 : (cm ? 1'b0 : m_pend[c]);
        end
        if (enable) m_fc = (m_fc + 1) % 256;
        if (din_valid && din_first) begin
            m_word = int'(din); m_cnt = 1; m_ch = int'(din_ch);
        end else if (din_valid && m_cnt == 1) begin
            m_word = m_word * 16 + int'(din); m_cnt = 2;
        end else if (m_cnt == 2) begin
            m_cnt = 0;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("pdm_out", 32'(pdm_out), 32'({m_out[1], m_out[0]}));
        check("pending", 32'(pending), 32'({m_pend[1], m_pend[0]}));
        check("load_overrun", 32'(load_overrun), 32'(m_ovr));
        check("frame_tick", 32'(frame_tick), 32'(enable && m_fc == 255));
    endtask

    task automatic idle();
        din_valid = 1'b0;
        din_first = 1'b0;
    endtask

    task automatic beat(input logic [3:0] d, input logic first, input logic ch);
        din = d; din_valid = 1'b1; din_first = first; din_ch = ch;
        tick();
        idle();
    endtask

    // Returns just after the shadow write edge.
    task automatic load(input logic ch, input logic [7:0] word);
        beat(word[7:4], 1'b1, ch);
        beat(word[3:0], 1'b0, ch);
        tick();
    endtask

    task automatic measure(output int ones0, output int ones1, output int ticks);
        ones0 = 0; ones1 = 0; ticks = 0;
        for (int i = 0; i < 256; i++) begin
            tick();
            ones0 += int'(pdm_out[0]);
            ones1 += int'(pdm_out[1]);
            ticks += int'(frame_tick);
        end
    endtask

    // Leaves the bench in the cycle where frame_tick is high.
    task automatic wait_frame();
        bit seen = 0;
        for (int i = 0; i < 600 && !seen; i++) begin
            tick();
            seen = frame_tick;
        end
        check("frame_wait", 32'(seen), 32'd1);
    endtask

    int o0, o1, tk;
    logic a, b;
    logic [1:0] held;

    initial begin
        model_reset();
        reset = 1'b1; enable = 1'b0; commit_mode = 1'b0;
        din = '0; din_ch = 1'b0; idle();

        // Reset and idle
        tick(); tick();
        check("rst_pdm", 32'(pdm_out), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_overrun", 32'(load_overrun), 32'd0);
        reset = 1'b0; enable = 1'b1;
        measure(o0, o1, tk);
        check("idle_ones0", 32'(o0), 32'd0);
        check("idle_ones1", 32'(o1), 32'd0);
        check("idle_frame_ticks", 32'(tk), 32'd1);

        // Immediate load of half scale on ch0
        load(1'b0, 8'h80);
        check("imm_pending_pulse", 32'(pending[0]), 32'd1);
        tick();
        check("imm_pending_clear", 32'(pending[0]), 32'd0);
        tick(); tick();
        a = pdm_out[0]; tick(); b = pdm_out[0];
        check("half_toggle", 32'(a ^ b), 32'd1);
        measure(o0, o1, tk);
        check("half_ones0", 32'(o0), 32'd128);
        check("half_ones1", 32'(o1), 32'd0);

        // Quarter density on ch1 with an abandoned first beat
        beat(4'h3, 1'b1, 1'b1);
        beat(4'h4, 1'b1, 1'b1);
        beat(4'h0, 1'b0, 1'b1);
        tick(); tick(); tick(); tick();
        measure(o0, o1, tk);
        check("quarter_ones1", 32'(o1), 32'd64);
        check("quarter_ones0", 32'(o0), 32'd128);

        // Frame-synchronised commit
        commit_mode = 1'b1;
        wait_frame();
        repeat (100) tick();
        load(1'b1, 8'hFF);
        check("frame_pending_set", 32'(pending[1]), 32'd1);
        wait_frame();
        check("frame_pending_hold", 32'(pending[1]), 32'd1);
        tick(); tick(); tick();
        check("frame_pending_clear", 32'(pending[1]), 32'd0);
        measure(o0, o1, tk);
        check("full_ones1", 32'(o1), 32'd255);

        // Overrun: two words for ch0 inside one frame, last one wins
        wait_frame();
        tick();
        load(1'b0, 8'h20);
        load(1'b0, 8'hA0);
        check("overrun_set", 32'(load_overrun), 32'd1);
        wait_frame();
        tick(); tick(); tick();
        measure(o0, o1, tk);
        check("overrun_ones0", 32'(o0), 32'd160);
        check("overrun_sticky", 32'(load_overrun), 32'd1);

        // Enable hold, then mid-operation reset
        commit_mode = 1'b0;
        load(1'b0, 8'h80);
        tick(); tick(); tick();
        enable = 1'b0;
        held = {m_out[1], m_out[0]};
        repeat (10) begin
            tick();
            check("hold_pdm", 32'(pdm_out), 32'(held));
            check("hold_no_tick", 32'(frame_tick), 32'd0);
        end
        enable = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mrst_pdm", 32'(pdm_out), 32'd0);
        check("mrst_pending", 32'(pending), 32'd0);
        check("mrst_overrun", 32'(load_overrun), 32'd0);
        measure(o0, o1, tk);
        check("mrst_ones0", 32'(o0), 32'd0);
        check("mrst_frame_ticks", 32'(tk), 32'd1);
        load(1'b0, 8'h80);
        tick(); tick(); tick();
        measure(o0, o1, tk);
        check("reload_ones0", 32'(o0), 32'd128);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            din_valid   = ($urandom_range(0, 1) == 1);
            din_first   = din_valid && ($urandom_range(0, 3) == 0);
            din         = 4'($urandom);
            din_ch      = 1'($urandom);
            if ($urandom_range(0, 99) == 0) commit_mode = ~commit_mode;
            enable      = ($urandom_range(0, 9) != 0);
            reset       = ($urandom_range(0, 999) == 0);
            tick();
        end
        reset = 1'b0; idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
